// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// The data side wins ties, and stall_o freezes the pipeline until every pending access is done.
module unified_mem_arbiter #(
  parameter int unsigned MEM_LAT       = 2,
  parameter logic [31:0] STALL_CNT_RST = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        dm_rd_i,
  input  logic        dm_wr_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] stall_cnt_o,
  output logic [1:0]  state_o
);

  // Handshake: a requester holds its level request (and address/data) until it sees a
  // one-cycle ack; the served flag stops the same request being issued twice while the
  // pipeline stays frozen, and is dropped on any edge where the pipeline advances.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic       owner_dm, owner_nxt;
  logic [3:0] lat_cnt, lat_nxt;
  logic       is_wr;
  logic       if_served, dm_served;
  logic       dm_req, if_pend, dm_pend;
  logic       start, go_ack, capture;

  assign dm_req  = dm_rd_i | dm_wr_i;
  assign if_pend = if_req_i & ~if_served;
  assign dm_pend = dm_req & ~dm_served;
  assign stall_o = (if_pend & ~if_ack_o) | (dm_pend & ~dm_ack_o);
  assign state_o = state;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner_dm;
    lat_nxt   = lat_cnt;
    start     = 1'b0;
    go_ack    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // The data access belongs to the older instruction, so it goes first.
        if (dm_pend) begin
          state_nxt = ISSUE;
          owner_nxt = 1'b1;
          start     = 1'b1;
        end else if (if_pend) begin
          state_nxt = ISSUE;
          owner_nxt = 1'b0;
          start     = 1'b1;
        end
      end
      ISSUE: begin
        if (is_wr) begin
          state_nxt = ACK;
          go_ack    = 1'b1;
        end else begin
          state_nxt = WAIT;
          lat_nxt   = LAT_INIT;
        end
      end
      WAIT: begin
        if (lat_cnt == 4'd0) begin
          state_nxt = ACK;
          go_ack    = 1'b1;
          capture   = 1'b1;
        end else begin
          lat_nxt = lat_cnt - 4'd1;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      owner_dm <= 1'b0;
      lat_cnt  <= 4'd0;
    end else begin
      state    <= state_nxt;
      owner_dm <= owner_nxt;
      lat_cnt  <= lat_nxt;
    end
  end

  // Command registers: the strobe is high only in ISSUE, address and data hold otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      is_wr       <= 1'b0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
    end else begin
      mem_en_o <= start;
      mem_we_o <= start & owner_nxt & dm_wr_i;
      if (start) begin
        is_wr      <= owner_nxt & dm_wr_i;
        mem_addr_o <= owner_nxt ? dm_addr_i : if_addr_i;
        if (owner_nxt) begin
          mem_wdata_o <= dm_wdata_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_ack_o   <= 1'b0;
      dm_ack_o   <= 1'b0;
      if_rdata_o <= 32'h0;
      dm_rdata_o <= 32'h0;
    end else begin
      if_ack_o <= go_ack & ~owner_dm;
      dm_ack_o <= go_ack & owner_dm;
      if (capture && !owner_dm) begin
        if_rdata_o <= mem_rdata_i;
      end
      if (capture && owner_dm) begin
        dm_rdata_o <= mem_rdata_i;
      end
    end
  end

  // An unstalled edge means the pipeline moved on, so any held request is a new one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_served   <= 1'b0;
      dm_served   <= 1'b0;
      stall_cnt_o <= STALL_CNT_RST;
    end else begin
      if (!stall_o) begin
        if_served <= 1'b0;
        dm_served <= 1'b0;
      end else begin
        if (if_ack_o) if_served <= 1'b1;
        if (dm_ack_o) dm_served <= 1'b1;
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port synchronous memory between the instruction-fetch path (IF stage, addressed by the program counter) and the data-memory path (MEM stage, addressed by the EX/MEM ALU result). It serialises the two requesters, sequences each access through a fixed-latency memory, returns read data with one-cycle acknowledge pulses, and drives a global stall that freezes the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers until every pending access of the current cycle has completed.

## Interface
- MEM_LAT, 2, memory read latency: cycles from the rising edge that samples mem_en_o to mem_rdata_i being valid; legal range 1..15
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request, level; held until if_ack_o
- if_addr_i  in  32  fetch address (PC)
- if_rdata_o  out  32  fetched instruction; registered; held until the next fetch ack
- if_ack_o  out  1  one-cycle pulse; if_rdata_o valid in the same cycle
- dm_rd_i  in  1  data read request, level
- dm_wr_i  in  1  data write request, level
- dm_addr_i  in  32  data address
- dm_wdata_i  in  32  write data
- dm_rdata_o  out  32  load data; registered; held until the next data read ack
- dm_ack_o  out  1  one-cycle pulse
- mem_en_o, mem_we_o  out  1 each  memory command strobe and write enable; registered
- mem_addr_o, mem_wdata_o  out  32 each  registered memory address and write data
- mem_rdata_i  in  32  memory read data
- stall_o  out  1  combinational pipeline freeze
- stall_cnt_o  out  32  count of cycles with stall_o=1; wraps 0xFFFFFFFF→0

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK. Registers: state, owner (IF/DM), is_wr, lat_cnt (4 bits), if_served, dm_served.
- A pending request is req & !served. In this block, dm_req = dm_rd_i | dm_wr_i.
- IDLE: if the DM request is pending, owner=DM; else if the IF request is pending, owner=IF; else stay. DM has priority because it belongs to the older instruction.
- IDLE to ISSUE: latch the address, the write data and is_wr (dm_wr_i wins if dm_rd_i and dm_wr_i are both high). The fetch path always reads.
- ISSUE: mem_en_o=1 and mem_we_o=is_wr for exactly this cycle. Next state: ACK if is_wr; otherwise WAIT with lat_cnt=MEM_LAT-1.
- WAIT: decrement lat_cnt. When lat_cnt=0, capture mem_rdata_i into the owner's rdata register and go to ACK.
- ACK: pulse the owner's ack, set the owner's served flag, then return to IDLE. A request still asserted during its ACK cycle is never re-issued.
- Served flags clear on every edge where stall_o=0, because that is when the pipeline advances.
- stall_o = (if_req_i & !if_served & !if_ack_o) | (dm_req & !dm_served & !dm_ack_o).
- mem_en_o and mem_we_o are 0 in every state other than ISSUE. mem_addr_o and mem_wdata_o hold their last values.
- Writes return no data and leave dm_rdata_o unchanged.

## Timing
- Reset values: state=IDLE, all served flags 0, lat_cnt 0, if_rdata_o=0, dm_rdata_o=0, if_ack_o=0, dm_ack_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, stall_cnt_o=0.
- Reset mid-access abandons the access with no ack. The first request after reset deasserts is treated as new.
- Read: request seen in IDLE at cycle 0, ISSUE in cycle 1, data captured at the end of cycle 1+MEM_LAT, ack in cycle 2+MEM_LAT. stall_o is high in cycles 0..1+MEM_LAT and low in the ack cycle.
- Write: ISSUE in cycle 1, ack in cycle 2, stall_o high in cycles 0..1.
- Both requests in the same cycle: the DM access runs to completion first, then the IF access starts in the IDLE cycle after the DM ACK. stall_o stays high continuously until the IF ack.
- Back-to-back fetches with no data traffic: a new fetch issues every MEM_LAT+3 cycles (IDLE, ISSUE, WAIT, ACK).
- A request that drops while the FSM is busy is still completed and acked; the ack is ignored and the served flag clears on the next unstalled edge.
- If dm_rd_i and dm_wr_i are both high, the access is a write.

## Test plan
- Reset then a single fetch with MEM_LAT=2, addr 0x0000_0010, memory returns 0x2002_0005: mem_en_o=1 in cycle 1 with mem_addr_o=0x10; if_ack_o in cycle 4 with if_rdata_o=0x2002_0005; stall_o high in cycles 0-3; stall_cnt_o=4.
- Simultaneous fetch at 0x14 and load at 0x40 (memory word 0xDEADBEEF): the DM command issues first; dm_ack_o arrives with 0xDEADBEEF; the IF command issues next; stall_o stays 1 with no gap until if_ack_o.
- Store 0x0000_00AA to 0x80: mem_we_o=1 with mem_wdata_o=0xAA in the ISSUE cycle; dm_ack_o one cycle later; dm_rdata_o unchanged.
- Requests held high through the ack cycle and into the next cycle after an unstalled edge: exactly one mem_en_o pulse per instruction and no duplicate ack.
- rst_i asserted in WAIT: all outputs return to their reset values immediately with no ack; the request issues again from IDLE after reset.
- MEM_LAT=1 and MEM_LAT=15: the read ack arrives 3 and 17 cycles after the request respectively. Preload stall_cnt_o near 0xFFFFFFFF through a long run of stalled cycles and confirm it wraps to 0.
